// File: rtl/w5500_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w5500_pkg : shared W5500 SPI frame definitions (states, control fields, OM)
// Rev 1.0
// ---------------------------------------------------------------------------
package w5500_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_CTRL    = 3'd3,
    ST_DATA    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int CTRL_BSB_MSB = 7;
  localparam int CTRL_BSB_LSB = 3;
  localparam int CTRL_RWB_BIT = 2;
  localparam int CTRL_OM_MSB  = 1;
  localparam int CTRL_OM_LSB  = 0;

  localparam logic [1:0] OM_VDM  = 2'b00;
  localparam logic [1:0] OM_FDM1 = 2'b01;
  localparam logic [1:0] OM_FDM2 = 2'b10;
  localparam logic [1:0] OM_FDM4 = 2'b11;

  // Zero means variable length: the frame runs until ss_n rises.
  function automatic logic [2:0] om_len(input logic [1:0] om);
    logic [2:0] len;
    len = 3'd0;
    case (om)
      OM_VDM:  len = 3'd0;
      OM_FDM1: len = 3'd1;
      OM_FDM2: len = 3'd2;
      OM_FDM4: len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/w5500_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w5500_sync : N-stage flip-flop synchronizer with a selectable reset value
// Rev 1.0
// ---------------------------------------------------------------------------
module w5500_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/w5500_spi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w5500_spi_responder : W5500-style SPI frame decoder (mode 0) issuing
//                       register write strobes and read requests. Rev 1.0
// ---------------------------------------------------------------------------
module w5500_spi_responder
  import w5500_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [4:0]  wr_bsb,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  output logic [4:0]  rd_bsb,
  input  logic [7:0]  rd_data,
  output logic        frame_active,
  output logic        frame_err
);

  logic sck_s, ss_s, mosi_s;

  w5500_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_s)
  );
  w5500_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(spi_ss_n), .q(ss_s)
  );
  w5500_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
  );

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic [15:0]            addr_q, addr_d;
  logic [4:0]             bsb_q, bsb_d;
  logic                   rwb_q, rwb_d;
  logic [1:0]             om_q, om_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   armed_q, armed_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic                   ld_q, ld_d;
  logic                   miso_q, miso_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [15:0]            wr_addr_q, wr_addr_d;
  logic [4:0]             wr_bsb_q, wr_bsb_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   rd_req_q, rd_req_d;
  logic [15:0]            rd_addr_q, rd_addr_d;
  logic [4:0]             rd_bsb_q, rd_bsb_d;
  logic                   frame_err_q, frame_err_d;

  logic       sck_rise, sck_fall, settled, byte_done;
  logic [7:0] byte_in;
  logic [2:0] fixed_len;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  // The ss_n chain holds its preset for SYNC_STAGES cycles after reset, so
  // it only counts as a genuine "seen high" once that preset has flushed.
  assign settled   = settle_q[SYNC_STAGES-1];
  assign byte_in   = {shift_q, mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign fixed_len = om_len(om_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    bsb_d       = bsb_q;
    rwb_d       = rwb_q;
    om_d        = om_q;
    sck_prev_d  = sck_s;
    settle_d    = {settle_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (settled & ss_s);
    ld_d        = rd_req_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_bsb_d    = wr_bsb_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_bsb_d    = rd_bsb_q;
    frame_err_d = 1'b0;

    if (ld_q) begin
      tx_d = rd_data;
    end

    if (state_q != ST_IDLE && ss_s) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      frame_err_d = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) ||
                    (state_q == ST_CTRL) ||
                    ((state_q == ST_DATA) && (bit_cnt_q != 3'd0));
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 3'd0;
          miso_d     = 1'b0;
          if (armed_q && !ss_s) begin
            state_d = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI, ST_ADDR_LO, ST_CTRL, ST_DATA: begin
          if (sck_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (state_q == ST_DATA && !rwb_q && sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (byte_done) begin
            case (state_q)
              ST_ADDR_HI: begin
                addr_d[15:8] = byte_in;
                state_d      = ST_ADDR_LO;
              end
              ST_ADDR_LO: begin
                addr_d[7:0] = byte_in;
                state_d     = ST_CTRL;
              end
              ST_CTRL: begin
                bsb_d      = byte_in[CTRL_BSB_MSB:CTRL_BSB_LSB];
                rwb_d      = byte_in[CTRL_RWB_BIT];
                om_d       = byte_in[CTRL_OM_MSB:CTRL_OM_LSB];
                byte_cnt_d = 3'd0;
                state_d    = ST_DATA;
                if (!byte_in[CTRL_RWB_BIT]) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = addr_q;
                  rd_bsb_d  = byte_in[CTRL_BSB_MSB:CTRL_BSB_LSB];
                end
              end
              default: begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                addr_d     = addr_q + 16'd1;
                if (rwb_q) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = addr_q;
                  wr_bsb_d   = bsb_q;
                  wr_data_d  = byte_in;
                end
                if (fixed_len != 3'd0 && (byte_cnt_q + 3'd1) == fixed_len) begin
                  state_d = ST_DONE;
                end else if (!rwb_q) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = addr_q + 16'd1;
                  rd_bsb_d  = bsb_q;
                end
              end
            endcase
          end
        end
        default: begin
          // ST_DONE: surplus bits are swallowed until ss_n rises.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      addr_q      <= 16'd0;
      bsb_q       <= 5'd0;
      rwb_q       <= 1'b0;
      om_q        <= 2'b00;
      sck_prev_q  <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      ld_q        <= 1'b0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 16'd0;
      wr_bsb_q    <= 5'd0;
      wr_data_q   <= 8'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 16'd0;
      rd_bsb_q    <= 5'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      bsb_q       <= bsb_d;
      rwb_q       <= rwb_d;
      om_q        <= om_d;
      sck_prev_q  <= sck_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      ld_q        <= ld_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_bsb_q    <= wr_bsb_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_bsb_q    <= rd_bsb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_oe  = (state_q == ST_DATA) && !rwb_q;
  assign spi_miso     = miso_q & spi_miso_oe;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_bsb       = wr_bsb_q;
  assign wr_data      = wr_data_q;
  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign rd_bsb       = rd_bsb_q;
  assign frame_active = (state_q != ST_IDLE);
  assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_w5500_spi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_w5500_spi_responder : scoreboard bench for the W5500 SPI responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_w5500_spi_responder;
  import w5500_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int HALF_SCK    = 50;

  typedef struct packed {
    logic [15:0] addr;
    logic [4:0]  bsb;
    logic [7:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [4:0]  bsb;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck, spi_ss_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        wr_valid, rd_req, frame_active, frame_err;
  logic [15:0] wr_addr, rd_addr;
  logic [4:0]  wr_bsb, rd_bsb;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;

  wr_exp_t wr_sb[$];
  rd_exp_t rd_sb[$];
  logic    miso_sb[$];

  always #5 clk = ~clk;

  w5500_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_bsb(wr_bsb), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_bsb(rd_bsb), .rd_data(rd_data),
    .frame_active(frame_active), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Register-file model: answers one cycle after each request.
  always @(posedge clk) begin
    if (rd_req) rd_data <= (rd_addr == 16'h0039) ? 8'h04 : 8'h77;
  end

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (wr_valid) begin
      if (wr_sb.size() == 0) begin
        check("wr_unexpected", {16'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_exp_t e;
        e = wr_sb.pop_front();
        check("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
        check("wr_bsb",  {27'd0, wr_bsb},  {27'd0, e.bsb});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
    if (rd_req) begin
      if (rd_sb.size() == 0) begin
        check("rd_unexpected", {16'd0, rd_addr}, 32'hFFFF_FFFF);
      end else begin
        rd_exp_t r;
        r = rd_sb.pop_front();
        check("rd_addr", {16'd0, rd_addr}, {16'd0, r.addr});
        check("rd_bsb",  {27'd0, rd_bsb},  {27'd0, r.bsb});
      end
    end
  end

  // Mode 0: drive mosi while sck is low, master samples miso at the rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit chk_miso);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #HALF_SCK;
      if (chk_miso) begin
        check("miso_oe", {31'd0, spi_miso_oe}, 32'd1);
        if (miso_sb.size() == 0) check("miso_underflow", 32'd0, 32'd1);
        else check("miso_bit", {31'd0, spi_miso}, {31'd0, miso_sb.pop_front()});
      end
      spi_sck = 1'b1;
      #HALF_SCK;
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    spi_ss_n = 1'b0;
    #(2 * HALF_SCK);
  endtask

  task automatic frame_end();
    #(2 * HALF_SCK);
    spi_ss_n = 1'b1;
    #(4 * HALF_SCK);
  endtask

  task automatic header(input logic [15:0] addr, input logic [7:0] ctrl);
    spi_bits(addr[15:8], 8, 1'b0);
    spi_bits(addr[7:0], 8, 1'b0);
    spi_bits(ctrl, 8, 1'b0);
  endtask

  initial begin
    int errs0;
    logic [7:0] exp_byte;
    rst = 1'b1;
    spi_sck = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {wr_valid, rd_req, frame_active, frame_err, spi_miso, spi_miso_oe},
          32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Variable-length write, three bytes
    wr_sb.push_back('{16'h0028, 5'h01, 8'hA5});
    wr_sb.push_back('{16'h0029, 5'h01, 8'h5A});
    wr_sb.push_back('{16'h002A, 5'h01, 8'hFF});
    frame_start();
    check("frame_active_hi", {31'd0, frame_active}, 32'd1);
    header(16'h0028, 8'h0C);
    spi_bits(8'hA5, 8, 1'b0);
    spi_bits(8'h5A, 8, 1'b0);
    spi_bits(8'hFF, 8, 1'b0);
    frame_end();
    check("frame_active_lo", {31'd0, frame_active}, 32'd0);

    // Variable-length read returning 0x04
    rd_sb.push_back('{16'h0039, 5'h00});
    rd_sb.push_back('{16'h003A, 5'h00});
    exp_byte = 8'h04;
    for (int i = 7; i >= 0; i--) miso_sb.push_back(exp_byte[i]);
    frame_start();
    header(16'h0039, 8'h00);
    spi_bits(8'h00, 8, 1'b1);
    frame_end();
    check("miso_oe_idle", {31'd0, spi_miso_oe}, 32'd0);
    check("miso_idle", {31'd0, spi_miso}, 32'd0);

    // Fixed one-byte write: second byte swallowed in DONE
    wr_sb.push_back('{16'h0100, 5'h00, 8'h11});
    frame_start();
    header(16'h0100, 8'h05);
    spi_bits(8'h11, 8, 1'b0);
    spi_bits(8'h22, 8, 1'b0);
    #(2 * HALF_SCK);
    check("fdm_state_done", {29'd0, dut.state_q}, {29'd0, ST_DONE});
    check("fdm_active", {31'd0, frame_active}, 32'd1);
    check("fdm_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    frame_end();

    // Aborted data byte after four bits
    errs0 = err_pulses;
    frame_start();
    header(16'h0010, 8'h04);
    spi_bits(8'hF0, 4, 1'b0);
    #(2 * HALF_SCK);
    @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("abort_idle", {31'd0, frame_active}, 32'd0);
    #(4 * HALF_SCK);
    check("abort_err_pulses", err_pulses - errs0, 32'd1);

    // Address wrap at 0xFFFF
    wr_sb.push_back('{16'hFFFF, 5'h00, 8'h01});
    wr_sb.push_back('{16'h0000, 5'h00, 8'h02});
    frame_start();
    header(16'hFFFF, 8'h04);
    spi_bits(8'h01, 8, 1'b0);
    spi_bits(8'h02, 8, 1'b0);
    frame_end();

    // Reset in the middle of the header; remaining bits must be ignored
    errs0 = err_pulses;
    frame_start();
    spi_bits(8'h12, 8, 1'b0);
    spi_bits(8'h34, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_outputs",
          {wr_valid, rd_req, frame_active, frame_err, spi_miso, spi_miso_oe},
          32'd0);
    rst = 1'b0;
    spi_bits(8'h34, 4, 1'b0);
    spi_bits(8'h04, 8, 1'b0);
    spi_bits(8'hEE, 8, 1'b0);
    check("midrst_inactive", {31'd0, frame_active}, 32'd0);
    frame_end();
    check("midrst_no_err", err_pulses - errs0, 32'd0);

    // Recovery frame after the reset
    wr_sb.push_back('{16'h0200, 5'h00, 8'h3C});
    frame_start();
    header(16'h0200, 8'h04);
    spi_bits(8'h3C, 8, 1'b0);
    frame_end();

    check("wr_sb_empty", wr_sb.size(), 32'd0);
    check("rd_sb_empty", rd_sb.size(), 32'd0);
    check("miso_sb_empty", miso_sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
